rda_seq_adder: RTL and testbench
================================

// Module: rda_seq_adder
// PURPOSE
//  Sequential recursive-doubling adder. Takes operands a, b and cin over a
//  valid/ready handshake and builds the kill/propagate/generate carry-status
//  vector. It resolves that vector in place with one doubling step per clock
//  (distance 1,2,4,...), reusing a single combine-stage row, then returns the
//  sum, carry-out and signed overflow over a second valid/ready handshake.
//  It is the time-multiplexed, handshaked counterpart of the unrolled
//  combinational doubling stages.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; must be >= 2
//  STEPS  localparam = clog2(WIDTH+1); number of doubling steps (5 for 16)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands present
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in
//  out_valid  out  1      result present
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  a+b+cin, low WIDTH bits
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow = carry(WIDTH) ^ carry(WIDTH-1)
// BEHAVIOUR
//  Status encoding (2b): 00 kill, 11 generate, 10 propagate; 01 never produced.
//  Vector st[0..WIDTH]: st[0] = cin ? 11 : 00.
//  st[i+1] from bit i: a&b -> 11, ~a&~b -> 00, else 10.
//  Combine (lo,hi): result = (hi==10) ? lo : hi.
//  Step k (k=0..STEPS-1), d=2^k: st[i] <= combine(st[i-d], st[i]) for i>=d;
//  st[i] unchanged for i<d. All entries update in parallel from old values.
//  After STEPS steps no entry is 10; carry into bit i is c[i] = st[i][1].
//  sum[i] = a[i]^b[i]^c[i]; cout = st[WIDTH][1]; ovf = c[WIDTH]^c[WIDTH-1].
//  a and b are latched on accept and held for the sum computation.
//  FSM states:
//   IDLE: in_ready=1. On in_valid, latch a/b/st and step=0, go to STEP.
//   STEP: one doubling step per edge, step++. On the edge applying the last
//         step (step==STEPS-1), register sum/cout/ovf and go to DONE.
//   DONE: out_valid=1. Outputs stay stable until out_ready is sampled high,
//         then go to IDLE.
//  Latency: if acceptance is at edge E0, out_valid is high from edge E0+STEPS
//  onward (5 edges for WIDTH=16). Throughput: at most 1 op per STEPS+2 cycles.
//  in_ready is 0 in STEP and DONE. in_valid is ignored then; operands are not
//  latched. The producer must hold its inputs until in_ready.
//  The handshake in DONE does not accept new operands on the same edge.
//  Reset (async, any state, including mid-STEP): state=IDLE, step=0, st=0,
//  sum=0, cout=0, ovf=0, out_valid=0. in_ready=1 while in IDLE.
//  An in-flight operation is discarded.
//  Wrap-around: sum is modulo 2^WIDTH; the overflowing bit is reported only
//  via cout.
// TESTING
//  1 a=FFFF b=0001 cin=0 -> sum=0000 cout=1 ovf=0; out_valid 5 edges after accept
//  2 a=7FFF b=0001 cin=0 -> sum=8000 cout=0 ovf=1
//  3 a=1234 b=4321 cin=1 -> sum=5556 cout=0 ovf=0
//  4 a=FFFF b=0000 cin=1 (full propagate chain) -> sum=0000 cout=1 ovf=0
//  5 out_ready low 4 cycles in DONE -> sum/cout/ovf/out_valid stable,
//    in_ready=0, a concurrent in_valid is not accepted
//  6 rst_n low during step 2 -> outputs 0 at once, in_ready=1 after release;
//    next op a=0001 b=0001 -> 0002. Then 2000 random ops match a+b+cin.

Source files
------------

// File: rtl/rda_seq_adder_if.sv
// Handshake bundle for the sequential recursive-doubling adder:
// an operand channel (a, b, cin) and a result channel (sum, cout, ovf).
interface rda_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/rda_seq_adder.sv
// Sequential recursive-doubling adder: resolves the kill/propagate/generate
// carry-status vector in place, one doubling distance (1,2,4,...) per clock.
module rda_seq_adder #(
    parameter int WIDTH = 16
) (
    input logic             clk,
    input logic             rst_n,
    rda_seq_adder_if.slave  bus
);
    localparam int STEPS  = $clog2(WIDTH + 1);
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DONE
    } state_t;

    state_t                     state;
    logic [STEP_W-1:0]          step;
    logic [WIDTH:0][1:0]        st;
    logic [WIDTH:0][1:0]        st_init;
    logic [WIDTH:0][1:0]        st_nxt;
    logic [STEPS-1:0][WIDTH:0][1:0] cand;
    logic [WIDTH:0]             carry;
    logic [WIDTH-1:0]           a_r;
    logic [WIDTH-1:0]           b_r;
    logic [WIDTH-1:0]           sum_r;
    logic                       cout_r;
    logic                       ovf_r;
    logic                       out_valid_r;
    logic                       in_ready_r;

    // A propagating upper span (10) takes its carry status from the span below.
    function automatic logic [1:0] combine(input logic [1:0] lo, input logic [1:0] hi);
        return (hi == 2'b10) ? lo : hi;
    endfunction

    assign st_init[0] = bus.cin ? 2'b11 : 2'b00;

    for (genvar i = 0; i < WIDTH; i++) begin : g_init
        assign st_init[i+1] = {bus.a[i] | bus.b[i], bus.a[i] & bus.b[i]};
    end

    // One candidate row per doubling distance; the current step picks its row.
    for (genvar k = 0; k < STEPS; k++) begin : g_step
        for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
            if (i >= (1 << k)) begin : g_comb
                assign cand[k][i] = combine(st[i-(1<<k)], st[i]);
            end else begin : g_keep
                assign cand[k][i] = st[i];
            end
        end
    end

    assign st_nxt = cand[step];

    for (genvar i = 0; i <= WIDTH; i++) begin : g_carry
        assign carry[i] = st_nxt[i][1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            step        <= '0;
            st          <= '0;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.a;
                        b_r        <= bus.b;
                        st         <= st_init;
                        step       <= '0;
                        in_ready_r <= 1'b0;
                        state      <= STEP;
                    end
                end
                STEP: begin
                    st <= st_nxt;
                    if (step == STEP_W'(STEPS - 1)) begin
                        sum_r       <= a_r ^ b_r ^ carry[WIDTH-1:0];
                        cout_r      <= carry[WIDTH];
                        ovf_r       <= carry[WIDTH] ^ carry[WIDTH-1];
                        out_valid_r <= 1'b1;
                        step        <= '0;
                        state       <= DONE;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_rda_seq_adder.sv
// Scoreboard bench for rda_seq_adder: stimulus pushes expected results,
// an independent monitor pops and compares on each output handshake.
module tb_rda_seq_adder;
    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rand_ready;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    rda_seq_adder_if #(.WIDTH(16)) bus ();

    rda_seq_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drive one operand set, push its expected result, optionally wait for the result.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 input logic [15:0] es, input logic ec, input logic eo,
                                 input bit wait_result, output int lat);
        int n;
        exp_t e;
        lat = -1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
            return;
        end
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        @(posedge clk);
        e.sum  = es;
        e.cout = ec;
        e.ovf  = eo;
        exp_q.push_back(e);
        #1;
        bus.in_valid = 1'b0;
        if (!wait_result) return;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.out_valid) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL result_timeout: out_valid stayed 0, expected 1");
            return;
        end
        lat = n;
    endtask

    // Monitor: a handshake completes on the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_output: got sum %h, expected no result", bus.sum);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sum",  32'(bus.sum),  32'(e.sum));
                    checkOutput("cout", 32'(bus.cout), 32'(e.cout));
                    checkOutput("ovf",  32'(bus.ovf),  32'(e.ovf));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int n;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] full;
        n_checks     = 0;
        n_fail       = 0;
        rand_ready   = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.cin      = 1'b0;
        bus.out_ready = 1'b1;
        #22;
        checkOutput("reset_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_sum",       32'(bus.sum),       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, lat);
        checkOutput("latency", 32'(lat), 32'd5);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, lat);
        applyStimulus(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b1, lat);
        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, lat);

        // Backpressure: result must hold and a new request must not be taken.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        applyStimulus(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1, lat);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'hAAAA;
            bus.b        = 16'h5555;
            @(posedge clk); #1;
            checkOutput("hold_sum",       32'(bus.sum),       32'h0007);
            checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold_in_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("release_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("release_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("no_extra_accept", 32'(bus.in_ready), 32'd1);

        // Reset while the operation sits at doubling step 2.
        applyStimulus(16'h0005, 16'h0006, 1'b0, 16'h000B, 1'b0, 1'b0, 1'b0, lat);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_sum",       32'(bus.sum),       32'd0);
        checkOutput("midreset_cout",      32'(bus.cout),      32'd0);
        checkOutput("midreset_ovf",       32'(bus.ovf),       32'd0);
        checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("postreset_in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("postreset_out_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1, lat);

        rand_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom_range(0, 1));
            full = 17'(ra) + 17'(rb) + 17'(rc);
            applyStimulus(ra, rb, rc, full[15:0], full[16],
                          (ra[15] == rb[15]) && (full[15] != ra[15]), 1'b1, lat);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
